// File: rtl/vending_fsm_param.sv
// ---------------------------------------------------------------------------
// vending_fsm_param
//
// A parametrised coin-operated vending controller. Coins of up to four
// denominations are added to a running credit. When the credit reaches PRICE
// the item is dispensed and any excess is returned as change. A cancel request
// returns the whole credit. The state is exported as a 2-bit output_code that
// keeps the legacy encoding (00 IDLE, 01 COLLECT, 10 VEND, 11 REFUND).
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   coin_valid    in   a coin is offered this cycle
//   coin_code     in   [1:0] denomination select (VAL0..VAL3)
//   cancel        in   request a refund of the current credit
//   vend          out  one-cycle pulse, item dispensed
//   change_valid  out  one-cycle pulse, change_amount carries a value
//   change_amount out  [CREDIT_W-1:0] change or refund, 0 when change_valid=0
//   credit        out  [CREDIT_W-1:0] accumulated credit
//   coin_reject   out  one-cycle pulse, the offered coin was returned
//   output_code   out  [1:0] current state
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module vending_fsm_param #(
  parameter int CREDIT_W = 7,
  parameter int PRICE    = 15,
  parameter int VAL0     = 5,
  parameter int VAL1     = 10,
  parameter int VAL2     = 25,
  parameter int VAL3     = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  output logic                vend,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic [1:0]          output_code
);

  // The encoding doubles as the external output_code, so the state register
  // can drive that port directly.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_VEND    = 2'b10,
    ST_REFUND  = 2'b11
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] VAL0_C  = CREDIT_W'(VAL0);
  localparam logic [CREDIT_W-1:0] VAL1_C  = CREDIT_W'(VAL1);
  localparam logic [CREDIT_W-1:0] VAL2_C  = CREDIT_W'(VAL2);
  localparam logic [CREDIT_W-1:0] VAL3_C  = CREDIT_W'(VAL3);

  state_t              state;
  state_t              state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] sum;

  logic                vend_next;
  logic                change_valid_next;
  logic [CREDIT_W-1:0] change_amount_next;
  logic                coin_reject_next;

  // Denomination lookup.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    coin_value = VAL0_C;
    unique case (coin_code)
      2'b00:   coin_value = VAL0_C;
      2'b01:   coin_value = VAL1_C;
      2'b10:   coin_value = VAL2_C;
      2'b11:   coin_value = VAL3_C;
      default: coin_value = VAL0_C;
    endcase
  end

  // Width is sufficient because CREDIT_W is sized for (PRICE-1)+max(VALn):
  // credit never exceeds PRICE-1 while coins are still being accepted.
  assign sum = credit + coin_value;

  // -------------------------------------------------------------------------
  // Process 1: state and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      credit        <= '0;
      vend          <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      coin_reject   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state         <= state_next;
      credit        <= credit_next;
      vend          <= vend_next;
      change_valid  <= change_valid_next;
      change_amount <= change_amount_next;
      coin_reject   <= coin_reject_next;
    end
  end

  assign output_code = state;

  // -------------------------------------------------------------------------
  // Process 2: next state and next credit
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    credit_next = credit;
    unique case (state)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          // Cancel beats a coin. With nothing collected there is nothing to
          // refund, so IDLE stays put.
          if (state == ST_COLLECT) state_next = ST_REFUND;
        end else if (coin_valid) begin
          credit_next = sum;
          state_next  = (sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
        end
      end
      ST_VEND, ST_REFUND: begin
        // Both are single-cycle payout states. The credit was paid out as
        // vend/change on entry, so it clears on exit.
        state_next  = ST_IDLE;
        credit_next = '0;
      end
      default: begin
        state_next  = ST_IDLE;
        credit_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: next values of the registered outputs
  // -------------------------------------------------------------------------
  // The pulses are computed from the state being entered, so they line up
  // with output_code on the same edge.
  always_comb begin
    vend_next          = 1'b0;
    change_valid_next  = 1'b0;
    change_amount_next = '0;

    // A coin is returned whenever it is not added. That happens during a
    // payout cycle, or when cancel arrives on the same cycle.
    coin_reject_next = coin_valid &&
                       (cancel || state == ST_VEND || state == ST_REFUND);

    unique case (state_next)
      ST_VEND: begin
        vend_next          = 1'b1;
        change_amount_next = credit_next - PRICE_C;
        change_valid_next  = (credit_next != PRICE_C);
      end
      ST_REFUND: begin
        change_amount_next = credit_next;
        change_valid_next  = 1'b1;
      end
      default: begin
        vend_next          = 1'b0;
        change_valid_next  = 1'b0;
        change_amount_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_vending_fsm_param.sv
// ---------------------------------------------------------------------------
// tb_vending_fsm_param
//
// Testbench for vending_fsm_param, built with the default parameters.
// It runs directed scenarios first, then a random coin/cancel/reset sequence.
// Each cycle's outputs are compared with a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_vending_fsm_param;

  localparam int CREDIT_W = 7;
  localparam int PRICE    = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic                coin_valid;
  logic [1:0]          coin_code;
  logic                cancel;
  logic                vend;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic [1:0]          output_code;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the credit held, plus whether the machine is
  // spending one cycle dispensing or refunding.
  int m_credit;
  bit m_dispensing;
  bit m_refunding;
  int e_vend, e_cv, e_ca, e_reject;

  vending_fsm_param #(
    .CREDIT_W(CREDIT_W), .PRICE(PRICE),
    .VAL0(5), .VAL1(10), .VAL2(25), .VAL3(50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .cancel       (cancel),
    .vend         (vend),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .output_code  (output_code)
  );

  always #5 clk = ~clk;

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'd0:    return 5;
      2'd1:    return 10;
      2'd2:    return 25;
      default: return 50;
    endcase
  endfunction

  function automatic int exp_code();
    if (m_dispensing) return 2;
    if (m_refunding)  return 3;
    return (m_credit > 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_credit     = 0;
    m_dispensing = 0;
    m_refunding  = 0;
    e_vend = 0; e_cv = 0; e_ca = 0; e_reject = 0;
  endtask

  // One clock edge worth of behaviour, taken from the machine's rules.
  task automatic model_step(input bit cv, input logic [1:0] cc, input bit cn);
    e_vend = 0; e_cv = 0; e_ca = 0; e_reject = 0;
    if (m_dispensing || m_refunding) begin
      m_credit     = 0;
      m_dispensing = 0;
      m_refunding  = 0;
      e_reject     = int'(cv);
    end else if (cn) begin
      e_reject = int'(cv);
      if (m_credit > 0) begin
        m_refunding = 1;
        e_cv        = 1;
        e_ca        = m_credit;
      end
    end else if (cv) begin
      m_credit += coin_val(cc);
      if (m_credit >= PRICE) begin
        m_dispensing = 1;
        e_vend       = 1;
        e_ca         = m_credit - PRICE;
        e_cv         = (e_ca != 0) ? 1 : 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vend"},          32'(vend),          32'(e_vend));
    check({tag, ".change_valid"},  32'(change_valid),  32'(e_cv));
    check({tag, ".change_amount"}, 32'(change_amount), 32'(e_ca));
    check({tag, ".credit"},        32'(credit),        32'(m_credit));
    check({tag, ".coin_reject"},   32'(coin_reject),   32'(e_reject));
    check({tag, ".output_code"},   32'(output_code),   32'(exp_code()));
  endtask

  // Apply inputs, let one rising edge take them, then compare 1ns later.
  task automatic step(input bit cv, input logic [1:0] cc, input bit cn,
                      input string tag);
    coin_valid = cv;
    coin_code  = cc;
    cancel     = cn;
    @(posedge clk);
    model_step(cv, cc, cn);
    #1;
    check_all(tag);
    coin_valid = 1'b0;
    cancel     = 1'b0;
  endtask

  // Async reset pulse placed mid-cycle, away from any clock edge.
  task automatic mid_cycle_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    cancel     = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #10;
    reset = 1'b1;

    // Two 10-unit coins: collect, then vend with 5 change, then idle.
    step(1'b1, 2'b01, 1'b0, "p1_coin1");
    step(1'b1, 2'b01, 1'b0, "p1_coin2");
    check("p1_change_const", 32'(change_amount), 32'd5);
    step(1'b0, 2'b00, 1'b0, "p1_idle");

    // Exact price with three 5-unit coins: vend, no change.
    step(1'b1, 2'b00, 1'b0, "p2_c1");
    step(1'b1, 2'b00, 1'b0, "p2_c2");
    step(1'b1, 2'b00, 1'b0, "p2_c3");
    check("p2_no_change_const", 32'(change_valid), 32'd0);
    step(1'b0, 2'b00, 1'b0, "p2_idle");

    // 10 then 25: change 20.
    step(1'b1, 2'b01, 1'b0, "p3_c1");
    step(1'b1, 2'b10, 1'b0, "p3_c2");
    check("p3_change_const", 32'(change_amount), 32'd20);
    step(1'b0, 2'b00, 1'b0, "p3_idle");

    // 5, then cancel plus coin: reject, and refund 5.
    step(1'b1, 2'b00, 1'b0, "p4_c1");
    step(1'b1, 2'b11, 1'b1, "p4_cancel");
    check("p4_refund_const", 32'(change_amount), 32'd5);
    step(1'b0, 2'b00, 1'b0, "p4_idle");

    // Coin offered during the VEND cycle is rejected; cancel in IDLE is silent.
    step(1'b1, 2'b01, 1'b0, "p5_c1");
    step(1'b1, 2'b01, 1'b0, "p5_c2");
    step(1'b1, 2'b10, 1'b0, "p5_coin_in_vend");
    step(1'b1, 2'b00, 1'b1, "p5_cancel_idle");
    step(1'b0, 2'b00, 1'b1, "p5_cancel_idle2");

    // Coin, then asynchronous reset mid-cycle: cleared, no refund afterwards.
    step(1'b1, 2'b01, 1'b0, "p6_c1");
    mid_cycle_reset("p6_async_rst");
    step(1'b0, 2'b00, 1'b0, "p6_post_rst");

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      bit         cv;
      bit         cn;
      logic [1:0] cc;
      cv = ($urandom_range(99) < 55);
      cn = ($urandom_range(99) < 15);
      cc = 2'($urandom_range(3));
      step(cv, cc, cn, "rand");
      if ($urandom_range(79) == 0) mid_cycle_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
